// File: rtl/display_fill_if.sv
// Command and display-memory write bundle for the rectangle-fill engine.
// master: command source (drives cmd_*), slave: the fill engine.
interface display_fill_if #(
    parameter int AW = 13,
    parameter int DW = 24
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [6:0]    cmd_x;
    logic [5:0]    cmd_y;
    logic [6:0]    cmd_w;
    logic [5:0]    cmd_h;
    logic [DW-1:0] cmd_color;
    logic          cmd_outline;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_web;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_outline,
        input  cmd_ready, busy, done, mem_waddr, mem_wdata, mem_web
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_outline,
        output cmd_ready, busy, done, mem_waddr, mem_wdata, mem_web
    );
endinterface

// File: rtl/display_fill.sv
// Rectangle-fill engine: one command in, one clipped pixel write per clock out.
// Optional perimeter-only mode is built when DISPLAY_FILL_OUTLINE_EN is defined.
module display_fill #(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter int AW   = 13,
    parameter int DW   = 24
) (
    input logic           clk,
    input logic           rst,
    display_fill_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [7:0]    COLS8  = 8'(COLS);
    localparam logic [6:0]    ROWS7  = 7'(ROWS);
    localparam logic [AW-1:0] STRIDE = AW'(COLS);

    state_t        state, state_d;
    logic [7:0]    col, col_d, ew_q;
    logic [6:0]    row, row_d, eh_q;
    logic [AW-1:0] row_base, base_d, addr_d;
    logic [6:0]    x_q;
    logic [DW-1:0] color_q, data_d;
    logic          web_d;
`ifdef DISPLAY_FILL_OUTLINE_EN
    logic          outline_q;
`endif

    // Command clipping against the right and bottom display edges.
    logic [7:0]    x8, w8, avail_w, ew_c;
    logic [6:0]    y7, h7, avail_h, eh_c;
    logic          empty, accept, row_end, last_px;
    logic [AW-1:0] y_base;

    assign x8      = {1'b0, bus.cmd_x};
    assign w8      = {1'b0, bus.cmd_w};
    assign avail_w = COLS8 - x8;
    assign ew_c    = (w8 < avail_w) ? w8 : avail_w;
    assign y7      = {1'b0, bus.cmd_y};
    assign h7      = {1'b0, bus.cmd_h};
    assign avail_h = ROWS7 - y7;
    assign eh_c    = (h7 < avail_h) ? h7 : avail_h;
    assign empty   = (x8 >= COLS8) | (y7 >= ROWS7) | (bus.cmd_w == 7'd0) | (bus.cmd_h == 6'd0);
    // Constant stride: reduces to shifts/adds, only used once per command for the start row.
    assign y_base  = AW'(bus.cmd_y) * STRIDE;

    assign bus.cmd_ready = (state == IDLE) & ~rst;
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign row_end       = (col == ew_q - 8'd1);
    assign last_px       = row_end & (row == eh_q - 7'd1);

    // Next state and next registered write (the write for the coming cycle).
    always_comb begin
        state_d = state;
        col_d   = col;
        row_d   = row;
        base_d  = row_base;
        addr_d  = bus.mem_waddr;
        data_d  = bus.mem_wdata;
        web_d   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (empty) begin
                        state_d = DONE;
                    end else begin
                        // First pixel is top-left, always on the perimeter.
                        state_d = FILL;
                        col_d   = 8'd0;
                        row_d   = 7'd0;
                        base_d  = y_base;
                        addr_d  = y_base + AW'(bus.cmd_x);
                        data_d  = bus.cmd_color;
                        web_d   = 1'b1;
                    end
                end
            end
            FILL: begin
                if (last_px) begin
                    state_d = DONE;
                end else begin
                    web_d = 1'b1;
                    if (row_end) begin
                        col_d  = 8'd0;
                        row_d  = row + 7'd1;
                        base_d = row_base + STRIDE;
                        addr_d = base_d + AW'(x_q);
                    end else begin
                        col_d  = col + 8'd1;
                        addr_d = bus.mem_waddr + AW'(1);
                    end
`ifdef DISPLAY_FILL_OUTLINE_EN
                    web_d = ~outline_q | (row_d == 7'd0) | (row_d == eh_q - 7'd1) |
                            (col_d == 8'd0) | (col_d == ew_q - 8'd1);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, walk counters and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            row_base      <= '0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.mem_web   <= 1'b0;
        end else begin
            state         <= state_d;
            col           <= col_d;
            row           <= row_d;
            row_base      <= base_d;
            bus.mem_waddr <= addr_d;
            bus.mem_wdata <= data_d;
            bus.mem_web   <= web_d;
        end
    end

    // Command capture; later changes on the command inputs are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            ew_q      <= '0;
            eh_q      <= '0;
            x_q       <= '0;
            color_q   <= '0;
`ifdef DISPLAY_FILL_OUTLINE_EN
            outline_q <= 1'b0;
`endif
        end else if (accept) begin
            ew_q      <= ew_c;
            eh_q      <= eh_c;
            x_q       <= bus.cmd_x;
            color_q   <= bus.cmd_color;
`ifdef DISPLAY_FILL_OUTLINE_EN
            outline_q <= bus.cmd_outline;
`endif
        end
    end

    // Colour is also held in mem_wdata for the whole walk; color_q is the captured copy.
    logic unused_color;
    assign unused_color = ^color_q;
endmodule

// File: doc/display_fill.md
Name: display_fill

Overview:
- Hardware rectangle-fill engine that writes solid-colour rectangles into the VGA display memory through the same write port the display interface consumes (waddr/wdata/web).
- Sits between a command source (CPU or test logic) and the display interface.
- Accepts one command per valid/ready handshake and emits one pixel write per clock.
- Turns the software per-pixel store loop into a single command.

Parameters:
COLS, 80, display columns; row stride of the linear address
ROWS, 60, display rows
AW, 13, display memory address width
DW, 24, pixel data width (8:8:8 RGB)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command
cmd_x  input  7  left column
cmd_y  input  6  top row
cmd_w  input  7  width in pixels
cmd_h  input  6  height in pixels
cmd_color  input  DW  fill colour
cmd_outline  input  1  perimeter-only mode (see Optional Feature)
busy  output  1  command accepted and not yet complete
done  output  1  one-cycle completion pulse
mem_waddr  output  AW  display memory write address = y*COLS + x
mem_wdata  output  DW  pixel colour
mem_web  output  1  write strobe, active high, one pixel per cycle asserted

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; busy=0; done=0; mem_web=0; mem_waddr=0; mem_wdata=0. cmd_ready=0 while rst is high.
- States: IDLE, FILL, DONE.
- cmd_ready = (state==IDLE) & ~rst. A command is accepted on the clk edge where cmd_valid & cmd_ready (cycle N).
- On accept, register the colour and the clipped extents:
  - ew = min(w, COLS-x); eh = min(h, ROWS-y).
  - If x>=COLS, y>=ROWS, w==0 or h==0, the rectangle is empty (k=0).
- Non-empty (k = ew*eh):
  - Go to FILL. Writes occur in cycles N+1..N+k, row-major: columns x..x+ew-1, then the next row.
  - Address generation uses a row-base register incremented by COLS per row plus a column offset. No multiplier.
  - mem_waddr, mem_wdata and mem_web are registered outputs.
- Empty: go straight to DONE at N+1 with no write.
- DONE lasts one cycle. done=1 in cycle N+k+1 (N+1 if empty), then return to IDLE. cmd_ready is high again in N+k+2.
- busy=1 from N+1 through the DONE cycle inclusive.
- mem_web=0 in every cycle outside FILL.
- cmd_valid is ignored while not in IDLE. Command inputs are sampled only at accept; later changes have no effect.
- Wrap: the column counter resets and the row base increments at end of row. FILL ends after the last pixel of row eh-1. Addresses never exceed COLS*ROWS-1.
- Reset mid-FILL: writes stop on the next edge (mem_web=0), state IDLE, no done pulse.
- Widths:
  - ew computed in 8 bits; eh computed in 7 bits.
  - Address sum computed in AW bits (COLS*ROWS must be <= 2^AW).

Optional Feature:
- Macro: DISPLAY_FILL_OUTLINE_EN.
- Defined: when cmd_outline=1 at accept, the engine still walks all k pixels with identical timing. mem_web is asserted only for perimeter pixels of the clipped rectangle: first/last clipped row, first/last clipped column.
- Not defined: cmd_outline is ignored; all rectangles are solid.
- Port list is identical in both builds.

Test Plan:
- Solid fill: x=2,y=3,w=3,h=2,color=24'hFF0000, accepted at N -> writes to 242,243,244,322,323,324 in N+1..N+6, all data FF0000; done pulses at N+7; cmd_ready high at N+8.
- Clipping: x=78,y=59,w=5,h=4 -> exactly two writes, to 4798 and 4799; done at N+3.
- Empty command: w=0 (or x=80) -> no mem_web; done at N+1; busy high for exactly one cycle.
- Back-to-back: cmd_valid held high with a second command during the first fill -> second not accepted until the cycle after done; no pixel of the second command appears before then.
- Reset mid-fill: 10x10 fill, rst asserted at N+5 -> mem_web=0 from N+6; no done pulse; cmd_ready high the cycle after rst drops.
- DISPLAY_FILL_OUTLINE_EN build, x=0,y=0,w=4,h=3,outline=1 -> writes to exactly 0,1,2,3,80,83,160,161,162,163 (10 writes); done at N+13.
